// File: rtl/demux2_pkg.sv
// Shared types and constants for the stream_demux2 1-to-2 stream demultiplexer.
// Optional beat counters are enabled with the DEMUX2_STATS_EN macro.
package demux2_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BURST_A = 2'b01,
    BURST_B = 2'b10
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam int DEFAULT_WIDTH = 2;
  localparam int DEFAULT_CNT_W = 8;

endpackage

// File: rtl/demux2_out_stage.sv
// One-entry valid/ready register slice; can_load tells the router it may push a beat.
// With DEMUX2_STATS_EN defined it also counts output handshakes.
import demux2_pkg::*;

module demux2_out_stage #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  output logic             can_load,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
`ifdef DEMUX2_STATS_EN
  output logic [CNT_W-1:0] count,
`endif
  output logic             last
);

  // A full stage may be replaced in the same cycle it is consumed.
  assign can_load = !valid || ready;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      last  <= load_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

`ifdef DEMUX2_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (valid && ready) begin
      count <= count + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/stream_demux2.sv
// Registered 1-to-2 stream demux: route is latched from s on a burst's first beat.
// Define DEMUX2_STATS_EN to add a_count/b_count handshake counters.
import demux2_pkg::*;

module stream_demux2 #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_last,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b_data,
`ifdef DEMUX2_STATS_EN
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count,
`endif
  output logic             b_last
);

  state_t state, state_next;
  logic   target;
  logic   accept;
  logic   a_can_load, b_can_load;
  logic   a_load, b_load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  assign accept = in_valid && in_ready;

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:             if (accept && !in_last) state_next = (s == SEL_B) ? BURST_B : BURST_A;
      BURST_A, BURST_B: if (accept && in_last)  state_next = IDLE;
      default:          state_next = IDLE;
    endcase
  end

  always_comb begin
    target = SEL_A;
    case (state)
      IDLE:    target = s;
      BURST_A: target = SEL_A;
      BURST_B: target = SEL_B;
      default: target = SEL_A;
    endcase
    // Only the target stage gates the input; the other one drains on its own.
    in_ready = !reset && ((target == SEL_B) ? b_can_load : a_can_load);
    a_load   = in_valid && in_ready && (target == SEL_A);
    b_load   = in_valid && in_ready && (target == SEL_B);
  end

  demux2_out_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_stage_a (
    .clk       (clk),
    .reset     (reset),
    .load      (a_load),
    .load_data (in_data),
    .load_last (in_last),
    .can_load  (a_can_load),
    .valid     (a_valid),
    .ready     (a_ready),
    .data      (a_data),
`ifdef DEMUX2_STATS_EN
    .count     (a_count),
`endif
    .last      (a_last)
  );

  demux2_out_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_stage_b (
    .clk       (clk),
    .reset     (reset),
    .load      (b_load),
    .load_data (in_data),
    .load_last (in_last),
    .can_load  (b_can_load),
    .valid     (b_valid),
    .ready     (b_ready),
    .data      (b_data),
`ifdef DEMUX2_STATS_EN
    .count     (b_count),
`endif
    .last      (b_last)
  );

endmodule

// File: doc/stream_demux2.md
Name: stream_demux2

Overview:
- Registered 1-to-2 stream demultiplexer; the distributing counterpart of the 2-way select mux.
- Routes a valid/ready input stream of WIDTH-bit beats to output A or B.
- The route is latched per burst: it is sampled from `s` on the first beat and held until the beat marked `in_last`.
- Each output has a one-entry register stage. Used wherever one producer feeds two consumers chosen per packet.

Parameters:
- WIDTH, 2, data beat width in bits.
- CNT_W, 8, width of optional beat counters.

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- s  input  1  route select: 0 = A, 1 = B; sampled only on a burst's first beat
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted when in_valid & in_ready
- in_data  input  WIDTH  input beat data
- in_last  input  1  final beat of burst
- a_valid  output  1  output A beat valid
- a_ready  input  1  output A consumer ready
- a_data  output  WIDTH  output A data
- a_last  output  1  output A last flag
- b_valid  output  1  output B beat valid
- b_ready  input  1  output B consumer ready
- b_data  output  WIDTH  output B data
- b_last  output  1  output B last flag

Behaviour:
- **Reset (async, while reset=1):**
  - a_valid=b_valid=0; a_data=b_data=0; a_last=b_last=0; FSM=IDLE.
  - in_ready forced to 0.
  - Counters (if present) = 0.
- **FSM states:** IDLE, BURST_A, BURST_B.
  - Target = (IDLE ? s : state's output).
  - IDLE: on an accepted beat with in_last=0, go to BURST_A (s=0) or BURST_B (s=1). With in_last=1 (single-beat burst), stay in IDLE.
  - BURST_x: s is ignored. An accepted beat with in_last=1 returns to IDLE; otherwise stay.
- **Output stage (per output):**
  - One register holding {valid, data, last}.
  - Stage can load = !x_valid | x_ready.
  - in_ready = !reset & (target stage can load).
  - Accepted beat loads the target stage: x_valid=1, data/last captured. Latency is 1 cycle from accept to x_valid.
- **Full throughput:** if the stage is full, its ready=1 and a new beat is accepted in the same cycle, the register is replaced. Sustains 1 beat/cycle per output.
- **Drain:** when x_valid & x_ready and no new load, x_valid clears next cycle. The non-target output drains independently of input activity.
- **Stall:** while x_valid & !x_ready, x_data and x_last hold stable. The stage is not overwritten and in_ready=0 while it is the target.
- in_valid=0: no state change other than drains.
- **Burst boundary:** the next burst may go to the other output in the cycle right after the last beat is accepted, even while the previous output is still stalled.
- **Reset mid-burst:** all held beats are discarded and the FSM returns to IDLE. There is no partial-burst recovery.
- Data/last are never inspected or modified.

Optional Feature:
- Macro: DEMUX2_STATS_EN.
- **Defined:** adds ports a_count and b_count (output, CNT_W each).
  - Each increments by 1 on its output handshake (x_valid & x_ready).
  - Wraps from 2^CNT_W-1 to 0. Reset to 0.
- **Undefined:** ports and counters are absent. All other behaviour is identical.

Decomposition:
- Package demux2_pkg:
  - State encoding: IDLE=2'b00, BURST_A=2'b01, BURST_B=2'b10.
  - Select constants SEL_A=1'b0, SEL_B=1'b1.
  - Default WIDTH and CNT_W.
- Sub-module demux2_out_stage: one-entry valid/ready register slice with a can_load output. Instantiated twice (A, B).
- FSM and in_ready logic live in the top.

Test Plan:
- Reset asserted mid-cycle → a_valid=b_valid=0 and in_ready=0 immediately; after release in_ready=1 with both readies high.
- s=0, 3-beat burst data 1,2,3 (last on 3), a_ready=1, s toggled to 1 on beat 2 → A outputs 1,2,3 on consecutive cycles, one cycle after each accept, a_last only with 3; B stays idle.
- Burst to B with b_ready=0 → first beat held on b_data, in_ready=0 until b_ready=1, no data change while stalled.
- A stalled (a_ready=0, A full), single-beat burst with s=1 and in_last=1 → accepted, b_valid=1 next cycle; A still holds its beat.
- Continuous back-to-back beats with a_ready=1 → one accept per cycle, no bubbles, in_ready constantly 1.
- DEMUX2_STATS_EN defined, CNT_W=2, 5 handshakes on A → a_count sequence 1,2,3,0,1; b_count stays 0.
